// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts two endpoints and a colour, then streams
// one pixel per accepted handshake in octant-normalised (possibly x/y-swapped) space.
module line_rasterizer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             red_in,
  input  logic             green_in,
  input  logic             blue_in,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [WIDTH-1:0] x_coord,
  output logic [WIDTH-1:0] y_coord,
  output logic             steep,
  output logic             red_out,
  output logic             green_out,
  output logic             blue_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, SETUP, INIT, DRAW, DONE} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        lx0, ly0, lx1, ly1;
  logic [WIDTH-1:0]        dx, dy;
  logic signed [WIDTH+1:0] err;
  logic                    ystep_neg;

  logic [WIDTH-1:0]        adx, ady, sx0, sy0, sx1, sy1;
  logic                    is_steep, do_swap;
  logic [WIDTH-1:0]        dx_init, dy_init, y_next;
  logic signed [WIDTH+1:0] err_init, err_sub, err_add;

  // SETUP: transpose steep lines, then order endpoints so x always increases
  always_comb begin
    adx      = (lx1 >= lx0) ? (lx1 - lx0) : (lx0 - lx1);
    ady      = (ly1 >= ly0) ? (ly1 - ly0) : (ly0 - ly1);
    is_steep = ady > adx;
    sx0      = is_steep ? ly0 : lx0;
    sy0      = is_steep ? lx0 : ly0;
    sx1      = is_steep ? ly1 : lx1;
    sy1      = is_steep ? lx1 : ly1;
    do_swap  = sx0 > sx1;
  end

  // err carries two extra bits so dx/2 - dy and the following + dx never overflow
  always_comb begin
    dx_init  = lx1 - lx0;
    dy_init  = (ly1 >= ly0) ? (ly1 - ly0) : (ly0 - ly1);
    err_init = $signed({2'b00, dx_init}) >>> 1;
    err_sub  = err - $signed({2'b00, dy});
    err_add  = err_sub + $signed({2'b00, dx});
    y_next   = ystep_neg ? (y_coord - 1'b1) : (y_coord + 1'b1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lx0       <= '0;
      ly0       <= '0;
      lx1       <= '0;
      ly1       <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      ystep_neg <= 1'b0;
      pix_valid <= 1'b0;
      x_coord   <= '0;
      y_coord   <= '0;
      steep     <= 1'b0;
      red_out   <= 1'b0;
      green_out <= 1'b0;
      blue_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lx0       <= x0;
            ly0       <= y0;
            lx1       <= x1;
            ly1       <= y1;
            red_out   <= red_in;
            green_out <= green_in;
            blue_out  <= blue_in;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          steep <= is_steep;
          lx0   <= do_swap ? sx1 : sx0;
          ly0   <= do_swap ? sy1 : sy0;
          lx1   <= do_swap ? sx0 : sx1;
          ly1   <= do_swap ? sy0 : sy1;
          state <= INIT;
        end
        INIT: begin
          dx        <= dx_init;
          dy        <= dy_init;
          err       <= err_init;
          ystep_neg <= ly1 < ly0;
          x_coord   <= lx0;
          y_coord   <= ly0;
          pix_valid <= 1'b1;
          state     <= DRAW;
        end
        DRAW: begin
          if (pix_valid && pix_ready) begin
            if (x_coord == lx1) begin
              pix_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              x_coord <= x_coord + 1'b1;
              if (err_sub[WIDTH+1]) begin
                y_coord <= y_next;
                err     <= err_add;
              end else begin
                err <= err_sub;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: table of lines with hand-derived pixel
// lists, plus backpressure, full-span diagonal and mid-line reset sequences.
`timescale 1ns/1ps
module tb_line_rasterizer;
  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst, start, pix_ready;
  logic [W-1:0] x0, y0, x1, y1;
  logic         red_in, green_in, blue_in;
  logic         pix_valid, steep, red_out, green_out, blue_out, busy, done;
  logic [W-1:0] x_coord, y_coord;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0][W-1:0] pix8_t;
  typedef struct packed {
    logic [W-1:0] x0, y0, x1, y1;
    logic         steep;
    logic [3:0]   n;
    logic [2:0]   rgb;
    pix8_t        px, py;
  } line_vec_t;

  line_vec_t vecs[8];

  line_rasterizer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pix_ready(pix_ready), .pix_valid(pix_valid),
    .x_coord(x_coord), .y_coord(y_coord), .steep(steep),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic pix8_t pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    pix8_t r;
    r[0] = a0[W-1:0]; r[1] = a1[W-1:0]; r[2] = a2[W-1:0]; r[3] = a3[W-1:0];
    r[4] = a4[W-1:0]; r[5] = a5[W-1:0]; r[6] = a6[W-1:0]; r[7] = a7[W-1:0];
    return r;
  endfunction

  function automatic line_vec_t mk(input int ax0, ay0, ax1, ay1, input int st,
                                   input int n, input int rgb, input pix8_t px, py);
    line_vec_t v;
    v.x0 = ax0[W-1:0]; v.y0 = ay0[W-1:0]; v.x1 = ax1[W-1:0]; v.y1 = ay1[W-1:0];
    v.steep = st[0]; v.n = n[3:0]; v.rgb = rgb[2:0]; v.px = px; v.py = py;
    return v;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int ax0, ay0, ax1, ay1, input int rgb);
    x0 = ax0[W-1:0]; y0 = ay0[W-1:0]; x1 = ax1[W-1:0]; y1 = ay1[W-1:0];
    {red_in, green_in, blue_in} = rgb[2:0];
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Draws one table line; stall_at >= 0 withholds pix_ready for 3 cycles at that pixel
  task automatic draw_line(input line_vec_t v, input string tag, input int stall_at);
    int k;
    int cyc;
    apply_stimulus(v.x0, v.y0, v.x1, v.y1, v.rgb);
    check_output({tag, " busy"}, busy, 1);
    check_output({tag, " valid early"}, pix_valid, 0);
    step();
    check_output({tag, " valid early2"}, pix_valid, 0);
    step();
    check_output({tag, " latency"}, pix_valid, 1);
    check_output({tag, " steep"}, steep, v.steep);
    check_output({tag, " colour"}, {red_out, green_out, blue_out}, v.rgb);
    k = 0;
    cyc = 0;
    while (pix_valid && cyc < 40) begin
      if (k == stall_at) begin
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          step();
          check_output($sformatf("%s hold%0d x", tag, i), x_coord, v.px[k]);
          check_output($sformatf("%s hold%0d y", tag, i), y_coord, v.py[k]);
          check_output($sformatf("%s hold%0d valid", tag, i), pix_valid, 1);
        end
        pix_ready = 1'b1;
      end
      if (k < int'(v.n)) begin
        check_output($sformatf("%s px%0d x", tag, k), x_coord, v.px[k]);
        check_output($sformatf("%s px%0d y", tag, k), y_coord, v.py[k]);
      end
      k++;
      step();
      cyc++;
    end
    check_output({tag, " count"}, k, v.n);
    check_output({tag, " done"}, done, 1);
    step();
    check_output({tag, " done pulse"}, done, 0);
    check_output({tag, " busy end"}, busy, 0);
    check_output({tag, " steep kept"}, steep, v.steep);
    check_output({tag, " colour kept"}, {red_out, green_out, blue_out}, v.rgb);
  endtask

  initial begin
    int cnt, bad, last_x, cyc, saw;
    vecs[0] = mk(0, 0, 4, 0, 0, 5, 3'b101, pk(0, 1, 2, 3, 4, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs[1] = mk(2, 1, 4, 7, 1, 7, 3'b010, pk(1, 2, 3, 4, 5, 6, 7, 0), pk(2, 2, 3, 3, 3, 4, 4, 0));
    vecs[2] = mk(5, 3, 1, 3, 0, 5, 3'b111, pk(1, 2, 3, 4, 5, 0, 0, 0), pk(3, 3, 3, 3, 3, 0, 0, 0));
    vecs[3] = mk(0, 5, 4, 1, 0, 5, 3'b100, pk(0, 1, 2, 3, 4, 0, 0, 0), pk(5, 4, 3, 2, 1, 0, 0, 0));
    vecs[4] = mk(7, 9, 7, 9, 0, 1, 3'b001, pk(7, 0, 0, 0, 0, 0, 0, 0), pk(9, 0, 0, 0, 0, 0, 0, 0));
    vecs[5] = mk(3, 2, 3, 6, 1, 5, 3'b110, pk(2, 3, 4, 5, 6, 0, 0, 0), pk(3, 3, 3, 3, 3, 0, 0, 0));
    vecs[6] = mk(8191, 8191, 8186, 8190, 0, 6, 3'b011,
                 pk(8186, 8187, 8188, 8189, 8190, 8191, 0, 0),
                 pk(8190, 8190, 8190, 8191, 8191, 8191, 0, 0));
    vecs[7] = mk(0, 8191, 2, 8184, 1, 8, 3'b101,
                 pk(8184, 8185, 8186, 8187, 8188, 8189, 8190, 8191),
                 pk(2, 2, 1, 1, 1, 1, 0, 0));

    rst = 1'b0; start = 1'b0; pix_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    red_in = 1'b0; green_in = 1'b0; blue_in = 1'b0;
    #12;
    check_output("reset valid", pix_valid, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset coords", {x_coord, y_coord}, 0);
    check_output("reset steep/colour", {steep, red_out, green_out, blue_out}, 0);
    step();
    rst = 1'b1;
    step();

    for (int i = 0; i < 8; i++) draw_line(vecs[i], $sformatf("line%0d", i), -1);

    draw_line(vecs[0], "bp", 2);

    // Full-span diagonal exercises the widest err excursion
    apply_stimulus(0, 0, 8191, 8191, 3'b111);
    step();
    step();
    check_output("diag steep", steep, 0);
    cnt = 0; bad = 0; last_x = -1; cyc = 0;
    while (pix_valid && cyc < 9000) begin
      if (x_coord != y_coord) bad++;
      if (int'(x_coord) != cnt) bad++;
      last_x = x_coord;
      cnt++;
      step();
      cyc++;
    end
    check_output("diag off-line pixels", bad, 0);
    check_output("diag count", cnt, 8192);
    check_output("diag last x", last_x, 8191);
    check_output("diag done", done, 1);
    step();

    // Mid-line reset during the third pixel of a 10-pixel line
    apply_stimulus(0, 0, 9, 0, 3'b111);
    step();
    step();
    step();
    step();
    check_output("rst mid px2", x_coord, 2);
    rst = 1'b0;
    #1;
    check_output("rst mid valid", pix_valid, 0);
    check_output("rst mid busy", busy, 0);
    check_output("rst mid coords", {x_coord, y_coord}, 0);
    check_output("rst mid steep/colour", {steep, red_out, green_out, blue_out}, 0);
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done || pix_valid) saw++;
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || pix_valid) saw++;
    end
    check_output("rst no activity", saw, 0);
    draw_line(vecs[3], "after rst", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 Parameter: WIDTH, default 13, width of every coordinate port and of the unsigned coordinate space.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-004 start  in  1  request to draw one line; sampled only in IDLE.
REQ-005 x0, y0, x1, y1  in  WIDTH each  unsigned endpoint coordinates; sampled with start.
REQ-006 red_in, green_in, blue_in  in  1 each  line colour; sampled with start.
REQ-007 pix_ready  in  1  downstream can accept the current pixel.
REQ-008 pix_valid  out  1  x_coord/y_coord/steep/colour form a valid pixel; drives the address generator's enable.
REQ-009 x_coord, y_coord  out  WIDTH each  pixel coordinate in swapped space; the consumer un-swaps using steep.
REQ-010 steep  out  1  1 = line was transposed (|dy| > |dx|).
REQ-011 red_out, green_out, blue_out  out  1 each  latched line colour.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  one-cycle pulse after the last pixel transfers.

Function
REQ-014 States: IDLE, SETUP, INIT, DRAW, DONE; encoding is free.
REQ-015 IDLE: start=1 latches endpoints and colour, sets busy, and moves to SETUP. start is ignored in every other state.
REQ-016 SETUP, one cycle: steep = |y1-y0| > |x1-x0|. If steep, swap x/y within each endpoint. Then, if x0 > x1, swap the endpoints. Go to INIT.
REQ-017 INIT, one cycle: dx = x1-x0; dy = |y1-y0|; err = dx>>1; ystep = +1 if y0<y1, else -1; x = x0; y = y0. Go to DRAW.
REQ-018 DRAW: pix_valid=1 presenting (x,y). A transfer occurs on a cycle with pix_valid & pix_ready.
REQ-019 On each transfer with x != x1: x += 1; err -= dy; if the new err < 0, then y += ystep and err += dx.
REQ-020 The transfer with x == x1 moves the block to DONE and drops pix_valid on the next cycle.
REQ-021 err is signed, WIDTH+2 bits. dx and dy are WIDTH bits. No overflow is permitted for any WIDTH-bit endpoints.
REQ-022 With pix_ready=0 in DRAW, x_coord, y_coord, steep, colour and pix_valid hold stable.
REQ-023 Latency: the first pixel_valid rises two cycles after the cycle in which start was accepted.
REQ-024 Sustained throughput is one pixel per cycle while pix_ready=1. Exactly dx+1 pixels are emitted per line.
REQ-025 DONE, one cycle: done=1, busy=0 on exit, return to IDLE. A new start is accepted the cycle after DONE.
REQ-026 Degenerate line (x0==x1 and y0==y1): steep=0, exactly one pixel emitted.
REQ-027 Horizontal and vertical lines: dy=0 gives no y steps; a vertical line gives steep=1 with y constant in swapped space.
REQ-028 Endpoints at 0 or 2^WIDTH-1 shall not wrap x or y.
REQ-029 steep and the colour outputs remain at the latched line values until the next start is accepted.

Reset
REQ-030 rst=0 asynchronously forces IDLE and clears these outputs to 0: pix_valid, busy, done, x_coord, y_coord, steep, red_out, green_out, blue_out.
REQ-031 rst=0 asynchronously clears internal err, dx and dy.
REQ-032 Reset asserted mid-line abandons the line: no further pixels, no done pulse.
REQ-033 After release, the first rising edge with start=1 is accepted normally.

Verification
REQ-034 (0,0)->(4,0), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0),(4,0), steep=0, first pix_valid 2 cycles after start, done one cycle after the 5th transfer.
REQ-035 (2,1)->(4,7) -> steep=1, pixels (1,2),(2,2),(3,3),(4,3),(5,3),(6,4),(7,4), 7 transfers.
REQ-036 (5,3)->(1,3) -> endpoints swapped, pixels x=1..5 with y=3, steep=0; (0,5)->(4,1) -> y descends 5,4,3,2,1.
REQ-037 (7,9)->(7,9) -> exactly one pixel (7,9), steep=0, then done.
REQ-038 Backpressure: (0,0)->(4,0), pix_ready=0 for 3 cycles while (2,0) is presented -> outputs held at (2,0) for those cycles, no pixel skipped or duplicated, 5 transfers total.
REQ-039 Reset mid-line: rst=0 during pixel 3 of (0,0)->(9,0) -> all outputs 0 immediately, no done pulse. A start after release draws the new line from its first pixel.
